ebpf_fetch_unit: RTL and testbench

Instruction fetch stage for the eBPF soft core, sitting directly upstream of the instruction store ROM and downstream-facing to the decoder. It owns the program counter, drives the ROM slot address, and captures the returned 64-bit slot into a registered valid/ready handoff to decode. It fuses the two-slot `lddw` wide-immediate form into one handoff, stops on `exit`, and accepts branch redirects from execute.

---
 rtl/ebpf_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_ebpf_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebpf_fetch_unit.sv
// eBPF fetch stage: owns the PC, addresses the slot ROM and registers each slot into a valid/ready handoff.
// Build option FETCH_LDDW_FUSE_EN: fuse the two-slot lddw into one handoff carrying the upper immediate.
module ebpf_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [7:0]  OPC_LDDW = 8'h18,
  parameter logic [7:0]  OPC_EXIT = 8'h95
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [63:0] imem_instr,
  output logic [63:0] out_instr,
  output logic [31:0] out_imm_hi,
  output logic [31:0] out_pc,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted
);

`ifdef FETCH_LDDW_FUSE_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WIDE = 2'd1, S_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_HALT = 2'd2} state_t;
`endif

  state_t      r_state, r_state_next;
  logic [31:0] r_pc, r_pc_next;
  logic [63:0] r_out_instr, r_out_instr_next;
  logic [31:0] r_out_pc, r_out_pc_next;
  logic        r_out_valid, r_out_valid_next;
`ifdef FETCH_LDDW_FUSE_EN
  logic [63:0] r_low, r_low_next;
  logic [31:0] r_out_imm_hi, r_out_imm_hi_next;
`else
  // Set while the slot under the PC is the immediate half of an lddw, so it is not decoded.
  logic        r_imm_slot, r_imm_slot_next;
`endif

  logic [7:0]  w_opcode;
  logic        w_free;
  logic        w_is_lddw;
  logic        w_is_exit;
  logic [31:0] w_pc_inc;

  assign w_opcode  = imem_instr[7:0];
  assign w_free    = !r_out_valid || out_ready;
  assign w_is_lddw = (w_opcode == OPC_LDDW);
  assign w_is_exit = (w_opcode == OPC_EXIT);
  assign w_pc_inc  = r_pc + 32'd1;

  always_comb begin
    r_state_next     = r_state;
    r_pc_next        = r_pc;
    r_out_instr_next = r_out_instr;
    r_out_pc_next    = r_out_pc;
    r_out_valid_next = r_out_valid;
`ifdef FETCH_LDDW_FUSE_EN
    r_low_next        = r_low;
    r_out_imm_hi_next = r_out_imm_hi;
`else
    r_imm_slot_next   = r_imm_slot;
`endif

    if (redirect_valid) begin
      // Redirect wins over stall and HALT; any half-fetched lddw is dropped.
      r_pc_next        = redirect_target;
      r_out_valid_next = 1'b0;
      r_state_next     = S_FETCH;
`ifndef FETCH_LDDW_FUSE_EN
      r_imm_slot_next  = 1'b0;
`endif
    end else if (w_free) begin
      case (r_state)
        S_FETCH: begin
          r_out_instr_next = imem_instr;
          r_out_pc_next    = r_pc;
          r_out_valid_next = 1'b1;
          r_pc_next        = w_pc_inc;
`ifdef FETCH_LDDW_FUSE_EN
          r_out_imm_hi_next = 32'h0;
          if (w_is_lddw) begin
            r_low_next       = imem_instr;
            r_out_valid_next = 1'b0;
            r_state_next     = S_WIDE;
          end else if (w_is_exit) begin
            r_pc_next    = r_pc;
            r_state_next = S_HALT;
          end
`else
          if (r_imm_slot) begin
            r_imm_slot_next = 1'b0;
          end else if (w_is_lddw) begin
            r_imm_slot_next = 1'b1;
          end else if (w_is_exit) begin
            r_pc_next    = r_pc;
            r_state_next = S_HALT;
          end
`endif
        end
`ifdef FETCH_LDDW_FUSE_EN
        S_WIDE: begin
          r_out_instr_next  = r_low;
          r_out_imm_hi_next = imem_instr[63:32];
          r_out_pc_next     = r_pc - 32'd1;
          r_out_valid_next  = 1'b1;
          r_pc_next         = w_pc_inc;
          r_state_next      = S_FETCH;
        end
`endif
        S_HALT: begin
          // Only the pending exit handoff can still drain here.
          r_out_valid_next = 1'b0;
        end
        default: begin
          r_state_next = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_out_instr <= 64'h0;
      r_out_pc    <= 32'h0;
      r_out_valid <= 1'b0;
`ifdef FETCH_LDDW_FUSE_EN
      r_low        <= 64'h0;
      r_out_imm_hi <= 32'h0;
`else
      r_imm_slot   <= 1'b0;
`endif
    end else begin
      r_state     <= r_state_next;
      r_pc        <= r_pc_next;
      r_out_instr <= r_out_instr_next;
      r_out_pc    <= r_out_pc_next;
      r_out_valid <= r_out_valid_next;
`ifdef FETCH_LDDW_FUSE_EN
      r_low        <= r_low_next;
      r_out_imm_hi <= r_out_imm_hi_next;
`else
      r_imm_slot   <= r_imm_slot_next;
`endif
    end
  end

  assign imem_addr = r_pc;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign out_valid = r_out_valid;
  assign halted    = (r_state == S_HALT);
`ifdef FETCH_LDDW_FUSE_EN
  assign out_imm_hi = r_out_imm_hi;
`else
  assign out_imm_hi = 32'h0;
`endif

endmodule

// File: tb/tb_ebpf_fetch_unit.sv
// Bench for ebpf_fetch_unit: directed scenarios plus random programs and random out_ready,
// scored against a program-walk model of the expected handoff sequence.
module tb_ebpf_fetch_unit;

  typedef struct packed {
    logic [63:0] instr;
    logic [31:0] imm;
    logic [31:0] pc;
  } ho_t;

  logic        clk;
  logic        rst0, rst1;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [63:0] rom [16];

  logic [31:0] imem_addr0, imem_addr1;
  logic [63:0] imem_instr0, imem_instr1;
  logic [63:0] out_instr0, out_instr1;
  logic [31:0] out_imm_hi0, out_imm_hi1;
  logic [31:0] out_pc0, out_pc1;
  logic        out_valid0, out_valid1;
  logic        halted0, halted1;

  logic        sel;
  logic [31:0] m_addr, m_imm, m_pc;
  logic [63:0] m_instr;
  logic        m_valid, m_halted;

  int vectors_applied = 0;
  int miscompares = 0;
  ho_t exp_q[$];

  assign imem_instr0 = rom[imem_addr0[3:0]];
  assign imem_instr1 = rom[imem_addr1[3:0]];

  ebpf_fetch_unit u_dut0 (
    .clk(clk), .rst(rst0), .imem_addr(imem_addr0), .imem_instr(imem_instr0),
    .out_instr(out_instr0), .out_imm_hi(out_imm_hi0), .out_pc(out_pc0),
    .out_valid(out_valid0), .out_ready(out_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halted(halted0)
  );

  ebpf_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_dut1 (
    .clk(clk), .rst(rst1), .imem_addr(imem_addr1), .imem_instr(imem_instr1),
    .out_instr(out_instr1), .out_imm_hi(out_imm_hi1), .out_pc(out_pc1),
    .out_valid(out_valid1), .out_ready(out_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halted(halted1)
  );

  always_comb begin
    m_addr   = sel ? imem_addr1  : imem_addr0;
    m_instr  = sel ? out_instr1  : out_instr0;
    m_imm    = sel ? out_imm_hi1 : out_imm_hi0;
    m_pc     = sel ? out_pc1     : out_pc0;
    m_valid  = sel ? out_valid1  : out_valid0;
    m_halted = sel ? halted1     : halted0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Walk the program as the decoder would see it; returns 0 if no exit is reached.
  function automatic bit build_model(input logic [31:0] start);
    logic [31:0] p, q;
    logic [63:0] s, s2;
    exp_q.delete();
    p = start;
    for (int n = 0; n < 40; n++) begin
      s = rom[p[3:0]];
      q = p + 32'd1;
      s2 = rom[q[3:0]];
      if (s[7:0] == 8'h18) begin
`ifdef FETCH_LDDW_FUSE_EN
        exp_q.push_back('{instr: s, imm: s2[63:32], pc: p});
`else
        exp_q.push_back('{instr: s, imm: 32'h0, pc: p});
        exp_q.push_back('{instr: s2, imm: 32'h0, pc: q});
`endif
        p = p + 32'd2;
      end else if (s[7:0] == 8'h95) begin
        exp_q.push_back('{instr: s, imm: 32'h0, pc: p});
        return 1'b1;
      end else begin
        exp_q.push_back('{instr: s, imm: 32'h0, pc: p});
        p = q;
      end
    end
    return 1'b0;
  endfunction

  task automatic gen_program();
    logic [31:0] a, b;
    logic [7:0]  op;
    int e;
    do begin
      for (int i = 0; i < 16; i++) begin
        a = $urandom;
        b = $urandom;
        do op = 8'($urandom_range(0, 255)); while (op == 8'h18 || op == 8'h95);
        if ($urandom_range(0, 4) == 0) op = 8'h18;
        rom[i] = {a, b[31:8], op};
      end
      e = $urandom_range(2, 14);
      rom[e] = {rom[e][63:8], 8'h95};
    end while (!build_model(32'h0));
  endtask

  task automatic run_program(input logic [31:0] start, input bit rand_ready);
    ho_t h;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    logic [63:0] p_instr;
    logic [31:0] p_pc, p_addr, exit_pc;
    if (!build_model(start)) begin
      check_value("model_no_exit", 64'd0, 64'd1);
      return;
    end
    exit_pc = exp_q[exp_q.size()-1].pc;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk);
      #1;
      if (prev_stall) begin
        check_value("stall_valid", {63'd0, m_valid}, 64'd1);
        check_value("stall_instr", m_instr, p_instr);
        check_value("stall_pc", {32'd0, m_pc}, {32'd0, p_pc});
        check_value("stall_addr", {32'd0, m_addr}, {32'd0, p_addr});
      end
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      prev_stall = m_valid && !out_ready;
      p_instr = m_instr;
      p_pc    = m_pc;
      p_addr  = m_addr;
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_value("extra_handoff", 64'd1, 64'd0);
        end else begin
          h = exp_q.pop_front();
          check_value("ho_instr", m_instr, h.instr);
          check_value("ho_imm_hi", {32'd0, m_imm}, {32'd0, h.imm});
          check_value("ho_pc", {32'd0, m_pc}, {32'd0, h.pc});
          if (exp_q.size() == 0) done = 1'b1;
        end
      end
    end
    if (!done) check_value("handoff_timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_value("halted", {63'd0, m_halted}, 64'd1);
    check_value("drained_valid", {63'd0, m_valid}, 64'd0);
    check_value("halt_addr", {32'd0, m_addr}, {32'd0, exit_pc});
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 64'h0;
  endtask

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    sel = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    clear_rom();
    rom[0] = 64'h0000000500000118;
    rom[1] = 64'h0000000700000000;
    rom[2] = 64'h0000000000000095;

    #12;
    check_value("rst_valid", {63'd0, out_valid0}, 64'd0);
    check_value("rst_instr", out_instr0, 64'd0);
    check_value("rst_imm_hi", {32'd0, out_imm_hi0}, 64'd0);
    check_value("rst_pc", {32'd0, out_pc0}, 64'd0);
    check_value("rst_halted", {63'd0, halted0}, 64'd0);
    check_value("rst_addr", {32'd0, imem_addr0}, 64'd0);
    check_value("rst_addr1", {32'd0, imem_addr1}, 64'h0000_0000_FFFF_FFFF);

    @(negedge clk) rst0 = 1'b1;
    run_program(32'h0, 1'b0);

    // Random programs, each entered from HALT through a redirect to slot 0.
    for (int k = 0; k < 12; k++) begin
      gen_program();
      @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_target = 32'h0;
      @(posedge clk);
      #1;
      check_value("redir_unhalt", {63'd0, halted0}, 64'd0);
      check_value("redir_valid", {63'd0, out_valid0}, 64'd0);
      check_value("redir_addr", {32'd0, imem_addr0}, 64'd0);
      redirect_valid = 1'b0;
      run_program(32'h0, 1'b1);
    end

    // Redirect to 10 right after an lddw slot has been taken.
    rst0 = 1'b0;
    clear_rom();
    rom[0]  = {32'h5, 24'h1, 8'h18};
    rom[1]  = {32'h9, 32'h0};
    rom[10] = {32'h1234, 24'h0, 8'h07};
    rom[11] = {32'h0, 24'h0, 8'h95};
    out_ready = 1'b1;
    @(negedge clk) rst0 = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_target = 32'd10;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check_value("wide_redir_valid", {63'd0, out_valid0}, 64'd0);
    check_value("wide_redir_addr", {32'd0, imem_addr0}, 64'd10);
    @(posedge clk);
    #1;
    check_value("tgt_valid", {63'd0, out_valid0}, 64'd1);
    check_value("tgt_pc", {32'd0, out_pc0}, 64'd10);
    check_value("tgt_instr", out_instr0, rom[10]);

    // Asynchronous reset in the middle of an lddw.
    rst0 = 1'b0;
    clear_rom();
    rom[0] = {32'h11, 24'h0, 8'h07};
    rom[1] = {32'h22, 24'h0, 8'h18};
    rom[2] = {32'h33, 32'h0};
    rom[3] = {32'h0, 24'h0, 8'h95};
    @(negedge clk) rst0 = 1'b1;
    @(posedge clk);
    #1;
    check_value("pre_rst_valid", {63'd0, out_valid0}, 64'd1);
    check_value("pre_rst_pc", {32'd0, out_pc0}, 64'd0);
    @(posedge clk);
    #3;
    rst0 = 1'b0;
    #1;
    check_value("arst_valid", {63'd0, out_valid0}, 64'd0);
    check_value("arst_instr", out_instr0, 64'd0);
    check_value("arst_imm_hi", {32'd0, out_imm_hi0}, 64'd0);
    check_value("arst_pc", {32'd0, out_pc0}, 64'd0);
    check_value("arst_addr", {32'd0, imem_addr0}, 64'd0);
    @(negedge clk) rst0 = 1'b1;
    run_program(32'h0, 1'b1);

    // PC wrap: lddw at FFFFFFFF takes its upper half from slot 0.
    clear_rom();
    rom[15] = {32'h1, 24'h0, 8'h18};
    rom[0]  = {32'hABCD, 24'h0, 8'h07};
    rom[1]  = {32'h2, 24'h0, 8'h07};
    rom[2]  = {32'h0, 24'h0, 8'h95};
    sel = 1'b1;
    @(negedge clk) rst1 = 1'b1;
    run_program(32'hFFFF_FFFF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
